// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives loads/stores on a req/ack data bus,
// steers sub-word lanes, and registers the MEM/WB values for writeback.
module mem_stage #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        EXMEM_valid_i,
   input  logic [31:0] EXMEM_alu_i,
   input  logic [31:0] EXMEM_store_data_i,
   input  logic [4:0]  EXMEM_reg_write_address_i,
   input  logic        EXMEM_ctrl_reg_write_i,
   input  logic        EXMEM_ctrl_mem_to_reg_i,
   input  logic        EXMEM_ctrl_mem_read_i,
   input  logic        EXMEM_ctrl_mem_write_i,
   input  logic [1:0]  EXMEM_ctrl_mem_size_i,
   input  logic        EXMEM_ctrl_mem_signed_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        MEM_stall_o,
   output logic        MEM_misaligned_o,
   output logic        MEM_bus_error_o,
   output logic [31:0] MEMWB_mem_o,
   output logic [31:0] MEMWB_alu_o,
   output logic [4:0]  MEMWB_reg_write_address_o,
   output logic        MEMWB_ctrl_reg_write_o,
   output logic        MEMWB_ctrl_mem_to_reg_o,
   output logic        dbg_state
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic        signed_q;

   logic        memop;
   logic        misaligned;
   logic        issue;
   logic        timeout_hit;
   logic [31:0] wdata_next;
   logic [3:0]  be_next;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   assign memop       = EXMEM_valid_i & (EXMEM_ctrl_mem_read_i | EXMEM_ctrl_mem_write_i);
   assign misaligned  = ((EXMEM_ctrl_mem_size_i == 2'b01) & EXMEM_alu_i[0]) |
                        (EXMEM_ctrl_mem_size_i[1] & (EXMEM_alu_i[1:0] != 2'b00));
   assign issue       = (state == IDLE) & memop & ~misaligned;
   assign timeout_hit = (cnt == TIMEOUT_LAST);

   assign dbg_state    = state;
   assign dmem_req_o   = (state == ACCESS);
   assign dmem_we_o    = (state == ACCESS) & we_q;
   assign dmem_be_o    = (state == ACCESS) ? be_q : 4'b0000;
   assign dmem_addr_o  = {addr_q[31:2], 2'b00};
   assign dmem_wdata_o = wdata_q;
   assign MEM_stall_o  = issue | ((state == ACCESS) & ~dmem_ack_i);

   always_comb begin
      wdata_next = EXMEM_store_data_i;
      be_next    = 4'b1111;
      case (EXMEM_ctrl_mem_size_i)
         2'b00: begin
            wdata_next = {4{EXMEM_store_data_i[7:0]}};
            be_next    = 4'b0001 << EXMEM_alu_i[1:0];
         end
         2'b01: begin
            wdata_next = {2{EXMEM_store_data_i[15:0]}};
            be_next    = 4'b0011 << {EXMEM_alu_i[1], 1'b0};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_lane = dmem_rdata_i[7:0];
      case (addr_q[1:0])
         2'b01:   byte_lane = dmem_rdata_i[15:8];
         2'b10:   byte_lane = dmem_rdata_i[23:16];
         2'b11:   byte_lane = dmem_rdata_i[31:24];
         default: ;
      endcase
      half_lane = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      load_data = dmem_rdata_i;
      case (size_q)
         2'b00:   load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
         2'b01:   load_data = {{16{signed_q & half_lane[15]}}, half_lane};
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state                     <= IDLE;
         cnt                       <= 8'd0;
         addr_q                    <= 32'd0;
         wdata_q                   <= 32'd0;
         be_q                      <= 4'd0;
         we_q                      <= 1'b0;
         size_q                    <= 2'd0;
         signed_q                  <= 1'b0;
         MEM_misaligned_o          <= 1'b0;
         MEM_bus_error_o           <= 1'b0;
         MEMWB_mem_o               <= 32'd0;
         MEMWB_alu_o               <= 32'd0;
         MEMWB_reg_write_address_o <= 5'd0;
         MEMWB_ctrl_reg_write_o    <= 1'b0;
         MEMWB_ctrl_mem_to_reg_o   <= 1'b0;
      end else begin
         MEM_misaligned_o <= 1'b0;
         MEM_bus_error_o  <= 1'b0;
         case (state)
            IDLE: begin
               MEMWB_alu_o               <= EXMEM_alu_i;
               MEMWB_reg_write_address_o <= EXMEM_reg_write_address_i;
               MEMWB_ctrl_mem_to_reg_o   <= EXMEM_ctrl_mem_to_reg_i;
               MEMWB_ctrl_reg_write_o    <= EXMEM_valid_i & EXMEM_ctrl_reg_write_i & ~memop;
               if (memop && misaligned) begin
                  MEM_misaligned_o <= 1'b1;
               end else if (issue) begin
                  // Read+write together is a store, so we follows the write flag alone.
                  addr_q   <= EXMEM_alu_i;
                  wdata_q  <= wdata_next;
                  be_q     <= be_next;
                  we_q     <= EXMEM_ctrl_mem_write_i;
                  size_q   <= EXMEM_ctrl_mem_size_i;
                  signed_q <= EXMEM_ctrl_mem_signed_i;
                  cnt      <= 8'd0;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (dmem_ack_i) begin
                  if (!we_q) MEMWB_mem_o <= load_data;
                  MEMWB_alu_o               <= EXMEM_alu_i;
                  MEMWB_reg_write_address_o <= EXMEM_reg_write_address_i;
                  MEMWB_ctrl_mem_to_reg_o   <= EXMEM_ctrl_mem_to_reg_i;
                  MEMWB_ctrl_reg_write_o    <= EXMEM_valid_i & EXMEM_ctrl_reg_write_i;
                  cnt                       <= 8'd0;
                  state                     <= IDLE;
               end else if (timeout_hit) begin
                  MEMWB_ctrl_reg_write_o <= 1'b0;
                  MEM_bus_error_o        <= 1'b1;
                  cnt                    <= 8'd0;
                  state                  <= IDLE;
               end else begin
                  MEMWB_ctrl_reg_write_o <= 1'b0;
                  cnt                    <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed expectations for ALU passthrough,
// loads, stores, misalignment, timeout and asynchronous reset.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [31:0] alu;
   logic [31:0] store_data;
   logic [4:0]  rd;
   logic        reg_write;
   logic        mem_to_reg;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic        mem_signed;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall;
   logic        misaligned;
   logic        bus_error;
   logic [31:0] wb_mem;
   logic [31:0] wb_alu;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        wb_mem_to_reg;
   logic        dbg_state;

   int n_compared = 0;
   int n_mismatched = 0;

   mem_stage #(.MEM_TIMEOUT(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .EXMEM_valid_i(valid), .EXMEM_alu_i(alu), .EXMEM_store_data_i(store_data),
      .EXMEM_reg_write_address_i(rd), .EXMEM_ctrl_reg_write_i(reg_write),
      .EXMEM_ctrl_mem_to_reg_i(mem_to_reg), .EXMEM_ctrl_mem_read_i(mem_read),
      .EXMEM_ctrl_mem_write_i(mem_write), .EXMEM_ctrl_mem_size_i(mem_size),
      .EXMEM_ctrl_mem_signed_i(mem_signed),
      .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
      .dmem_wdata_o(dmem_wdata), .dmem_be_o(dmem_be), .dmem_ack_i(dmem_ack),
      .dmem_rdata_i(dmem_rdata), .MEM_stall_o(stall), .MEM_misaligned_o(misaligned),
      .MEM_bus_error_o(bus_error), .MEMWB_mem_o(wb_mem), .MEMWB_alu_o(wb_alu),
      .MEMWB_reg_write_address_o(wb_rd), .MEMWB_ctrl_reg_write_o(wb_reg_write),
      .MEMWB_ctrl_mem_to_reg_o(wb_mem_to_reg), .dbg_state(dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read before the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bubble();
      valid = 1'b0; alu = 32'd0; store_data = 32'd0; rd = 5'd0;
      reg_write = 1'b0; mem_to_reg = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      mem_size = 2'b10; mem_signed = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
   endtask

   task automatic set_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn,
                           input logic [4:0] dst);
      set_bubble();
      valid = 1'b1; alu = a; mem_size = sz; mem_signed = sgn; rd = dst;
      mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
   endtask

   task automatic set_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      set_bubble();
      valid = 1'b1; alu = a; mem_size = sz; store_data = d; mem_write = 1'b1;
   endtask

   // Issue cycle plus ack_at ACCESS cycles; ack (with rdata) in the last one.
   task automatic run_access(input int ack_at, input logic [31:0] rdata, output int stall_cycles);
      stall_cycles = 0;
      #1;
      if (stall) stall_cycles++;
      tick();
      for (int k = 1; k <= ack_at; k++) begin
         if (k == ack_at) begin
            dmem_ack = 1'b1;
            dmem_rdata = rdata;
         end
         #1;
         if (stall) stall_cycles++;
         if (k < ack_at) check("bubble_while_waiting", {31'd0, wb_reg_write}, 32'd0);
         check("req_in_access", {31'd0, dmem_req}, 32'd1);
         tick();
      end
      dmem_ack = 1'b0;
   endtask

   int sc;

   initial begin
      set_bubble();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wb_alu", wb_alu, 32'd0);
      check("rst_req", {31'd0, dmem_req}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      rst = 1'b0;
      tick();

      // ALU op passthrough
      set_bubble();
      valid = 1'b1; alu = 32'h0000_1234; rd = 5'd5; reg_write = 1'b1;
      #1 check("alu_stall", {31'd0, stall}, 32'd0);
      tick();
      check("alu_wb_alu", wb_alu, 32'h0000_1234);
      check("alu_wb_rw", {31'd0, wb_reg_write}, 32'd1);
      check("alu_wb_rd", {27'd0, wb_rd}, 32'd5);

      // lw at 0x100, ack in 3rd ACCESS cycle
      set_load(32'h0000_0100, 2'b10, 1'b0, 5'd7);
      run_access(3, 32'hDEAD_BEEF, sc);
      check("lw_stall_cycles", sc, 32'd3);
      check("lw_data", wb_mem, 32'hDEAD_BEEF);
      check("lw_m2r", {31'd0, wb_mem_to_reg}, 32'd1);
      check("lw_rw", {31'd0, wb_reg_write}, 32'd1);
      check("lw_rd", {27'd0, wb_rd}, 32'd7);
      set_bubble();

      // lb signed at 0x103
      set_load(32'h0000_0103, 2'b00, 1'b1, 5'd8);
      run_access(1, 32'h80FF_0000, sc);
      check("lb_data", wb_mem, 32'hFFFF_FF80);
      check("lb_stall_cycles", sc, 32'd1);

      // lhu / lh at 0x102, lbu at 0x101
      set_load(32'h0000_0102, 2'b01, 1'b0, 5'd9);
      run_access(1, 32'h8001_0000, sc);
      check("lhu_data", wb_mem, 32'h0000_8001);
      set_load(32'h0000_0102, 2'b01, 1'b1, 5'd9);
      run_access(2, 32'h8001_0000, sc);
      check("lh_data", wb_mem, 32'hFFFF_8001);
      set_load(32'h0000_0101, 2'b00, 1'b0, 5'd10);
      run_access(1, 32'h0000_9A00, sc);
      check("lbu_data", wb_mem, 32'h0000_009A);

      // sb 0xA5 at 0x201
      set_store(32'h0000_0201, 2'b00, 32'h1234_56A5);
      #1 check("sb_stall_issue", {31'd0, stall}, 32'd1);
      tick();
      check("sb_be", {28'd0, dmem_be}, 32'h2);
      check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
      check("sb_addr", dmem_addr, 32'h0000_0200);
      check("sb_we", {31'd0, dmem_we}, 32'd1);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      check("sb_wb_rw", {31'd0, wb_reg_write}, 32'd0);
      check("sb_idle_be", {28'd0, dmem_be}, 32'd0);

      // sh 0xBEEF at 0x206
      set_store(32'h0000_0206, 2'b01, 32'h0000_BEEF);
      tick();
      check("sh_be", {28'd0, dmem_be}, 32'hC);
      check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
      check("sh_addr", dmem_addr, 32'h0000_0204);
      dmem_ack = 1'b1;
      tick();
      set_bubble();

      // misaligned sw at 0x102
      set_store(32'h0000_0102, 2'b10, 32'h1111_2222);
      reg_write = 1'b1;
      #1 check("mis_stall", {31'd0, stall}, 32'd0);
      tick();
      set_bubble();
      check("mis_pulse", {31'd0, misaligned}, 32'd1);
      check("mis_req", {31'd0, dmem_req}, 32'd0);
      check("mis_rw", {31'd0, wb_reg_write}, 32'd0);
      tick();
      check("mis_pulse_end", {31'd0, misaligned}, 32'd0);

      // timeout: no ack in 4 ACCESS cycles
      set_load(32'h0000_0300, 2'b10, 1'b0, 5'd11);
      tick();
      for (int k = 1; k <= 4; k++) begin
         #1;
         check("to_stall", {31'd0, stall}, 32'd1);
         check("to_no_err", {31'd0, bus_error}, 32'd0);
         tick();
      end
      set_bubble();
      #1;
      check("to_err_pulse", {31'd0, bus_error}, 32'd1);
      check("to_stall_released", {31'd0, stall}, 32'd0);
      check("to_req_low", {31'd0, dmem_req}, 32'd0);
      check("to_rw", {31'd0, wb_reg_write}, 32'd0);
      tick();
      check("to_err_end", {31'd0, bus_error}, 32'd0);

      // ack in the timeout cycle wins
      set_load(32'h0000_0304, 2'b10, 1'b0, 5'd12);
      run_access(4, 32'h0BAD_F00D, sc);
      check("late_ack_no_err", {31'd0, bus_error}, 32'd0);
      check("late_ack_data", wb_mem, 32'h0BAD_F00D);
      check("late_ack_rw", {31'd0, wb_reg_write}, 32'd1);
      set_bubble();
      tick();

      // async reset in the middle of ACCESS
      set_load(32'h0000_0400, 2'b10, 1'b0, 5'd13);
      tick();
      check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_req", {31'd0, dmem_req}, 32'd0);
      check("arst_wb_alu", wb_alu, 32'd0);
      check("arst_wb_mem", wb_mem, 32'd0);
      check("arst_wb_rd", {27'd0, wb_rd}, 32'd0);
      set_bubble();
      tick();
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
